// File: rtl/multiplicador_param_if.sv
// Start/result handshake bundle for multiplicador_param.
interface multiplicador_param_if #(
  parameter int unsigned WIDTH = 4
);
  logic               St;
  logic               Sinal;
  logic [WIDTH-1:0]   Multiplicando;
  logic [WIDTH-1:0]   Multiplicador;
  logic [2*WIDTH-1:0] Produto;
  logic               Done;
  logic               Idle;

  modport master (
    output St, Sinal, Multiplicando, Multiplicador,
    input  Produto, Done, Idle
  );

  modport slave (
    input  St, Sinal, Multiplicando, Multiplicador,
    output Produto, Done, Idle
  );
endinterface

// File: rtl/multiplicador_param.sv
// Sequential shift-add multiplier, WIDTH-bit operands, optional two's-complement mode.
// Signed operands are multiplied as magnitudes and the sign is applied in FIX.
module multiplicador_param #(
  parameter int unsigned WIDTH = 4
) (
  input logic                  Clk,
  input logic                  Rst_n,
  multiplicador_param_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e               state_q, state_d;
  logic                 st_q;
  logic                 neg_q, neg_d;
  logic                 zero_q, zero_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH:0]       acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic                 start;
  logic                 a_msb, b_msb;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   raw;

  assign start = bus.St & ~st_q;
  assign a_msb = bus.Multiplicando[WIDTH-1];
  assign b_msb = bus.Multiplicador[WIDTH-1];
  // Magnitude of the most-negative value still fits unsigned in WIDTH bits.
  assign a_abs = (bus.Sinal && a_msb) ? -bus.Multiplicando : bus.Multiplicando;
  assign b_abs = (bus.Sinal && b_msb) ? -bus.Multiplicador : bus.Multiplicador;
  assign sum   = q_q[0] ? (acc_q + {1'b0, m_q}) : acc_q;
  assign raw   = {acc_q[WIDTH-1:0], q_q};

  always_comb begin
    state_d = state_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          neg_d   = bus.Sinal & (a_msb ^ b_msb);
          zero_d  = (bus.Multiplicando == '0) || (bus.Multiplicador == '0);
          m_d     = a_abs;
          q_d     = b_abs;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = zero_d ? StFix : StCalc;
        end
      end
      StCalc: begin
        // Conditional add followed by a one-bit right shift of {ACC,Q}.
        acc_d = {1'b0, sum[WIDTH:1]};
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (zero_q) begin
          prod_d = '0;
        end else if (neg_q) begin
          prod_d = -raw;
        end else begin
          prod_d = raw;
        end
        state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= StIdle;
      st_q    <= 1'b1;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= bus.St;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.Produto = prod_q;
  assign bus.Done    = (state_q == StDone);
  assign bus.Idle    = (state_q == StIdle);
endmodule
